dm_arb_ctrl: RTL
================

# dm_arb_ctrl

Access controller for the single-port 4 KiB data memory (10-bit word address, synchronous write, combinational read). Arbitrates between the pipeline MEM stage (port A) and a debug/loader port (port B). Implements MIPS byte/halfword loads with sign/zero extension, and byte/halfword stores as two-cycle read-modify-write. Sits between the MEM stage and the data memory; stalls the pipeline via `a_ready`.

## Interface
- `ADDR_W`, 12: byte-address bits used; memory word address is `[ADDR_W-1:2]`.
- `MAX_WAIT`, 8: cycles port B may wait while A holds the memory before B is forced a slot.

- `clk` in 1: single clock, all state updates on rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `a_req` in 1: A request; held with all A fields stable until `a_ready`.
- `a_we` in 1: 1 = store, 0 = load.
- `a_size` in 2: 00 byte, 01 half, 10 word; 11 is treated as word.
- `a_sext` in 1: loads only; 1 = sign-extend, 0 = zero-extend.
- `a_addr` in 32: byte address; only `[ADDR_W-1:0]` used.
- `a_wdata` in 32: store data, right-justified for byte/half.
- `a_ready` out 1: transaction completes this cycle.
- `a_rdata` out 32: load result; valid when `a_ready & !a_we`, else 0.
- `a_err` out 1: misaligned access, valid with `a_ready`.
- `b_req` in 1, `b_we` in 1, `b_addr` in 32, `b_wdata` in 32: B request (word only; `b_addr[1:0]` ignored).
- `b_ready` out 1, `b_rdata` out 32: B completion; `b_rdata` = memory word when `b_ready & !b_we`, else 0.
- `m_addr` out ADDR_W-2: memory word address.
- `m_din` out 32: memory write data.
- `m_we` out 1: memory write enable.
- `m_dout` in 32: memory read data (combinational from `m_addr`).
- `busy` out 1: high while in RMW_WR.

## Operation
- States: IDLE, RMW_WR. Registers: state, `wait_cnt` (saturates at MAX_WAIT), `hold_addr`, `hold_data`.
- Grant in IDLE, evaluated each cycle:
  - B wins if `b_req && (!a_req || wait_cnt == MAX_WAIT)`.
  - Otherwise A wins if `a_req`.
  - Otherwise no grant.
- `wait_cnt`:
  - Increments each cycle `b_req` is high and B is not granted, including RMW_WR cycles.
  - Clears on B grant or when `b_req` is low.
- B grant: single cycle. `m_addr=b_addr[ADDR_W-1:2]`, `m_we=b_we`, `m_din=b_wdata`, `b_ready=1`.
- A grant, misaligned: half with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - `a_ready=1`, `a_err=1`, `m_we=0`, `a_rdata=0`.
- A load: single cycle, `m_addr` from `a_addr`, `a_ready=1`.
  - Byte lanes are big-endian: offset 0 = `[31:24]`, offset 3 = `[7:0]`; half offset 0 = `[31:16]`.
  - Selected lane is extended per `a_sext`.
- A word store: single cycle, `m_we=1`, `m_din=a_wdata`, `a_ready=1`.
- A byte/half store:
  - IDLE cycle: `m_we=0`; latch `hold_addr` and `hold_data` = `m_dout` with the addressed lane replaced by `a_wdata[7:0]` / `[15:0]`; `a_ready=0`; go to RMW_WR.
  - RMW_WR cycle: `m_addr=hold_addr`, `m_din=hold_data`, `m_we=1`, `a_ready=1`; return to IDLE.
  - RMW is atomic: B is never granted in RMW_WR.
- Idle outputs: `m_we=0`, readys 0, `m_addr` = A address when `a_req`, else 0.

## Timing
- Reset (`rst_n`=0 at edge):
  - State → IDLE; `wait_cnt`, `hold_*` → 0.
  - While `rst_n` is low, `a_ready`, `b_ready`, `m_we`, `a_err`, `busy` are forced 0.
- Reset in RMW_WR aborts the write; memory is unchanged.
- Latency from grant: load, word store, error and B access complete in 0 extra cycles. Sub-word store takes 2 cycles.
- A and B never see ready in the same cycle.
- Stalled B: `b_ready` is asserted no later than MAX_WAIT+2 cycles after `b_req` rises, counting one RMW.
- `m_we` is asserted at most one cycle per granted store.

## Structure
- Package `dm_ctrl_pkg`: size encodings (`SZ_B`, `SZ_H`, `SZ_W`) and state enum.
- Sub-module `dm_lane`: combinational lane extract/extend and lane merge. Instantiated once for loads and once for the RMW merge.

## Test plan
- Loads, with mem[0x10>>2]=0x8877_66F5 and `a_req` only:
  - lb @0x10 → `a_rdata`=0xFFFF_FF88.
  - lbu @0x13 → 0x0000_00F5.
  - lh @0x12 → 0x0000_66F5, sign extension not triggered.
  - lw @0x10 → 0x8877_66F5.
  - All have `a_ready` in the request cycle.
- Sub-word store: sb 0xAB @0x11 to word 0x1122_3344 → `a_ready` low for 1 cycle, then high with `m_we`=1. Memory = 0x11AB_3344. `busy`=1 for exactly 1 cycle.
- Misaligned: lh @0x21 → `a_err`=1, `a_ready`=1. sw @0x22 → `a_err`=1, memory unchanged, `m_we` never 1.
- Starvation: A issues back-to-back loads while B requests a write of 0xDEAD_BEEF @0x40 with MAX_WAIT=8 → `b_ready` after exactly 8 waiting cycles; A stalled 1 cycle; memory updated.
- Atomic RMW: B raises `b_req` during the IDLE cycle of an A sh → A RMW_WR completes first; B granted the following cycle.
- Reset mid-RMW: sb in progress, `rst_n`=0 at the RMW_WR edge → memory unchanged. After release, all outputs are 0 until a new request.

Source files
------------

// File: rtl/dm_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: access sizes, FSM states
// and the alignment rule used by the arbiter.
package dm_ctrl_pkg;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;

  typedef enum logic [0:0] {
    StIdle,
    StRmwWr
  } state_e;

  // Size 2'b11 behaves as a word, so bit 1 alone marks a full-word access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return ((size == SZ_H) && off[0]) || (size[1] && (off != 2'b00));
  endfunction

endpackage

// File: rtl/dm_lane.sv
// Big-endian byte/halfword lane logic: extracts and extends a load lane, or merges
// right-justified store data into the addressed lane of a memory word.
module dm_lane
  import dm_ctrl_pkg::*;
(
  input  logic        merge_i,
  input  logic [31:0] word_i,
  input  logic [1:0]  size_i,
  input  logic [1:0]  off_i,
  input  logic        sext_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] result_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] ext;
  logic [31:0] merged;

  always_comb begin
    unique case (off_i)
      2'd0:    byte_lane = word_i[31:24];
      2'd1:    byte_lane = word_i[23:16];
      2'd2:    byte_lane = word_i[15:8];
      default: byte_lane = word_i[7:0];
    endcase
    half_lane = off_i[1] ? word_i[15:0] : word_i[31:16];

    case (size_i)
      SZ_B:    ext = {{24{sext_i & byte_lane[7]}}, byte_lane};
      SZ_H:    ext = {{16{sext_i & half_lane[15]}}, half_lane};
      default: ext = word_i;
    endcase

    merged = word_i;
    case (size_i)
      SZ_B: begin
        unique case (off_i)
          2'd0:    merged[31:24] = wdata_i[7:0];
          2'd1:    merged[23:16] = wdata_i[7:0];
          2'd2:    merged[15:8]  = wdata_i[7:0];
          default: merged[7:0]   = wdata_i[7:0];
        endcase
      end
      SZ_H: begin
        if (off_i[1]) merged[15:0] = wdata_i[15:0];
        else          merged[31:16] = wdata_i[15:0];
      end
      default: merged = wdata_i;
    endcase

    result_o = merge_i ? merged : ext;
  end

endmodule

// File: rtl/dm_arb_ctrl.sv
// Data-memory access controller: arbitrates the MEM stage (A) against a debug/loader
// port (B), with sub-word loads and two-cycle read-modify-write sub-word stores.
module dm_arb_ctrl
  import dm_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_size,
  input  logic              a_sext,
  input  logic [31:0]       a_addr,
  input  logic [31:0]       a_wdata,
  output logic              a_ready,
  output logic [31:0]       a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [31:0]       b_addr,
  input  logic [31:0]       b_wdata,
  output logic              b_ready,
  output logic [31:0]       b_rdata,
  output logic [ADDR_W-3:0] m_addr,
  output logic [31:0]       m_din,
  output logic              m_we,
  input  logic [31:0]       m_dout,
  output logic              busy
);

  localparam int unsigned WordW = ADDR_W - 2;
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [WaitW-1:0] WaitMax = WaitW'(MAX_WAIT);

  state_e           state_q, state_d;
  logic [WaitW-1:0] wait_q, wait_d;
  logic [WordW-1:0] hold_addr_q, hold_addr_d;
  logic [31:0]      hold_data_q, hold_data_d;

  logic [WordW-1:0] a_word, b_word;
  logic [1:0]       a_off;
  logic             a_sub, a_mis, b_win, a_win;
  logic [31:0]      load_data, merge_data;

  logic unused_addr;
  assign unused_addr = ^{a_addr[31:ADDR_W], b_addr[31:ADDR_W], b_addr[1:0]};

  assign a_word = a_addr[ADDR_W-1:2];
  assign b_word = b_addr[ADDR_W-1:2];
  assign a_off  = a_addr[1:0];
  assign a_sub  = !a_size[1];
  assign a_mis  = misaligned(a_size, a_off);

  // B only overtakes a requesting A once it has waited the full budget.
  assign b_win = (state_q == StIdle) && b_req && (!a_req || (wait_q == WaitMax));
  assign a_win = (state_q == StIdle) && a_req && !b_win;

  dm_lane u_load_lane (
    .merge_i  (1'b0),
    .word_i   (m_dout),
    .size_i   (a_size),
    .off_i    (a_off),
    .sext_i   (a_sext),
    .wdata_i  (a_wdata),
    .result_o (load_data)
  );

  dm_lane u_merge_lane (
    .merge_i  (1'b1),
    .word_i   (m_dout),
    .size_i   (a_size),
    .off_i    (a_off),
    .sext_i   (a_sext),
    .wdata_i  (a_wdata),
    .result_o (merge_data)
  );

  always_comb begin
    a_ready = 1'b0;
    a_err   = 1'b0;
    a_rdata = '0;
    b_ready = 1'b0;
    b_rdata = '0;
    m_we    = 1'b0;
    m_din   = '0;
    m_addr  = a_req ? a_word : '0;

    if (state_q == StRmwWr) begin
      m_addr  = hold_addr_q;
      m_din   = hold_data_q;
      m_we    = 1'b1;
      a_ready = 1'b1;
    end else if (b_win) begin
      m_addr  = b_word;
      m_din   = b_wdata;
      m_we    = b_we;
      b_ready = 1'b1;
      b_rdata = b_we ? '0 : m_dout;
    end else if (a_win) begin
      if (a_mis) begin
        a_ready = 1'b1;
        a_err   = 1'b1;
      end else if (!a_we) begin
        a_ready = 1'b1;
        a_rdata = load_data;
      end else if (!a_sub) begin
        m_we    = 1'b1;
        m_din   = a_wdata;
        a_ready = 1'b1;
      end
      // Sub-word store: this cycle only reads the old word for the merge.
    end

    if (!rst_n) begin
      a_ready = 1'b0;
      a_err   = 1'b0;
      a_rdata = '0;
      b_ready = 1'b0;
      b_rdata = '0;
      m_we    = 1'b0;
    end
  end

  assign busy = rst_n && (state_q == StRmwWr);

  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;

    if (!b_req || b_win) begin
      wait_d = '0;
    end else if (wait_q != WaitMax) begin
      wait_d = wait_q + WaitW'(1);
    end

    if (state_q == StRmwWr) begin
      state_d = StIdle;
    end else if (a_win && a_we && a_sub && !a_mis) begin
      state_d     = StRmwWr;
      hold_addr_d = a_word;
      hold_data_d = merge_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      wait_q      <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
    end
  end

endmodule
